uart_imem_loader: RTL
=====================

UART_IMEM_LOADER -- requirements
Module: uart_imem_loader

Interface
REQ-001 SHALL have parameter CLK_DIV, default 235, meaning clocks per UART bit (legal range 16..1023).
REQ-002 SHALL have parameter WORD_BYTES, default 4, meaning bytes per imem word (legal values 1, 2, 4).
REQ-003 SHALL have parameter ADDR_W, default 6, meaning imem address width.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 23_500_000, meaning idle clocks in LOAD before load terminates.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic rising-edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port rx, input, 1 bit: UART serial in, 8N1, idle high.
REQ-008 SHALL have port load_en, input, 1 bit: loader enable; low forces state HUNT.
REQ-009 SHALL have port tx, output, 1 bit: UART serial out, idle high.
REQ-010 SHALL have port imem_we, output, 1 bit: one-cycle imem write strobe.
REQ-011 SHALL have port imem_addr, output, ADDR_W bits: write address.
REQ-012 SHALL have port imem_wdata, output, 8*WORD_BYTES bits: write data.
REQ-013 SHALL have port loading, output, 1 bit: high while in LOAD.
REQ-014 SHALL have port done, output, 1 bit: high while in DONE.
REQ-015 SHALL have port frame_err, output, 1 bit: sticky flag set on any stop bit sampled low.

Function
REQ-016 SHALL run a receiver that detects a falling edge on rx, samples at CLK_DIV/2 to confirm the start bit, samples 8 data bits LSB-first at CLK_DIV intervals, then samples the stop bit.
REQ-017 SHALL, when the receiver sees a start bit that reads high at mid-bit, treat it as a glitch and return to idle with no byte.
REQ-018 SHALL deliver each received byte as a one-cycle internal rx_valid pulse, issued after the stop-bit sample.
REQ-019 SHALL, when the stop bit reads low, discard the byte and set frame_err.
REQ-020 SHALL implement state machine HUNT -> LOAD -> DONE -> HUNT.
REQ-021 SHALL, in HUNT, match bytes against the 9-byte key "TECTUINNO" using a match index.
REQ-022 SHALL, on a key mismatch in HUNT, set the match index to 1 if the byte is "T", else to 0.
REQ-023 SHALL enter LOAD on the cycle after the 9th key byte matches, clearing the address, byte lane and timeout counter.
REQ-024 SHALL, in LOAD, pack bytes little-endian: the first byte of a word goes to bits [7:0].
REQ-025 SHALL, when the byte that completes a word is received, assert imem_we for exactly one cycle, on the cycle after that byte's rx_valid, with the current imem_addr and the assembled imem_wdata; imem_addr SHALL increment on the following cycle.
REQ-026 SHALL let imem_addr wrap from 2^ADDR_W-1 to 0 with no flag.
REQ-027 SHALL clear the timeout counter on every rx_valid in LOAD and increment it on every other cycle.
REQ-028 SHALL go from LOAD to DONE when the timeout counter reaches TIMEOUT_CYC.
REQ-029 SHALL, on timeout with a partial word pending, first write that word zero-padded in the upper lanes (one imem_we pulse), then enter DONE.
REQ-030 SHALL remain in DONE until load_en is low, then go to HUNT.
REQ-031 SHALL, when load_en is low in any state, go to HUNT on the next cycle, drop any partial word, and keep imem_we low.
REQ-032 SHALL, when load_en falls and a receive completes on the same cycle, give load_en priority and ignore the byte.
REQ-033 SHALL keep imem_wdata and imem_addr stable whenever imem_we is low, except for the addr increment (REQ-025) and clearing on LOAD entry (REQ-023).

Reset
REQ-034 SHALL, on rst low at a clk edge, set state to HUNT, match index to 0, imem_we 0, imem_addr 0, imem_wdata 0, loading 0, done 0, frame_err 0, tx 1, receiver and transmitter idle.
REQ-035 SHALL abort any in-flight received or transmitted frame on reset mid-frame; tx SHALL return high on the next cycle.
REQ-036 SHALL clear frame_err only by reset.

Configuration
REQ-037 SHALL provide macro UART_IMEM_LOADER_ECHO_EN.
REQ-038 SHALL, with UART_IMEM_LOADER_ECHO_EN defined, retransmit each byte accepted in LOAD on tx (8N1, CLK_DIV clocks per bit), starting within 2 cycles of rx_valid.
REQ-039 SHALL, with UART_IMEM_LOADER_ECHO_EN defined, drop an echo when the transmitter is busy; write behaviour SHALL be unaffected.
REQ-040 SHALL, without UART_IMEM_LOADER_ECHO_EN, tie tx constantly to 1 and include no transmitter logic.

Verification
REQ-041 SHALL cover: load_en=1, send "TECTUINNO" then 0x13,0x05,0x00,0x00 -> one imem_we, addr 0, wdata 0x00000513; then loading=1.
REQ-042 SHALL cover: send "TECTTECTUINNO" -> LOAD entered after the final "O" only; no imem_we before key completion.
REQ-043 SHALL cover: in LOAD, send 0xAA,0xBB then idle TIMEOUT_CYC clocks -> imem_we with wdata 0x0000BBAA, then done=1.
REQ-044 SHALL cover: ADDR_W=2, send 5 full words -> addresses 0,1,2,3,0.
REQ-045 SHALL cover: byte with low stop bit in LOAD -> frame_err=1, no lane advance, next good byte lands in lane 0.
REQ-046 SHALL cover: drop load_en mid-word, or pulse rst mid-frame -> HUNT, no imem_we; echo build tx mirrors 0x13 bit-exact at CLK_DIV=16.

Source files
------------

// File: rtl/uart_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : uart_imem_loader
// Purpose  : UART boot loader. Hunts for the key "TECTUINNO", then packs the
//            received bytes little-endian into imem words until the line goes
//            idle. Optional byte echo on tx is enabled by UART_IMEM_LOADER_ECHO_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_imem_loader #(
  parameter int CLK_DIV     = 235,
  parameter int WORD_BYTES  = 4,
  parameter int ADDR_W      = 6,
  parameter int TIMEOUT_CYC = 23_500_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rx,
  input  logic                    load_en,
  output logic                    tx,
  output logic                    imem_we,
  output logic [ADDR_W-1:0]       imem_addr,
  output logic [8*WORD_BYTES-1:0] imem_wdata,
  output logic                    loading,
  output logic                    done,
  output logic                    frame_err
);

  localparam int                  c_DIV_W    = $clog2(CLK_DIV);
  localparam logic [c_DIV_W-1:0]  c_BIT_LAST = c_DIV_W'(CLK_DIV - 1);
  localparam logic [c_DIV_W-1:0]  c_HALF_LAST = c_DIV_W'(CLK_DIV / 2 - 1);
  localparam int                  c_LANE_W   = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [c_LANE_W-1:0] c_LAST_LANE = c_LANE_W'(WORD_BYTES - 1);
  localparam int                  c_TO_W     = $clog2(TIMEOUT_CYC + 2);
  localparam logic [c_TO_W-1:0]   c_TIMEOUT  = c_TO_W'(TIMEOUT_CYC);
  localparam logic [3:0]          c_KEY_LAST = 4'd8;

  function automatic logic [7:0] key_byte(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd3: key_byte = 8'h54;  // T
      4'd1:       key_byte = 8'h45;  // E
      4'd2:       key_byte = 8'h43;  // C
      4'd4:       key_byte = 8'h55;  // U
      4'd5:       key_byte = 8'h49;  // I
      4'd6, 4'd7: key_byte = 8'h4E;  // N
      4'd8:       key_byte = 8'h4F;  // O
      default:    key_byte = 8'h00;
    endcase
  endfunction

  // ---------------------------------------------------------------- receiver
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t          r_rx_state, w_rx_next;
  logic               r_rx_s1, r_rx_s2, r_rx_prev;
  logic [c_DIV_W-1:0] r_rx_cnt;
  logic [2:0]         r_rx_bit;
  logic [7:0]         r_rx_shift, r_rx_byte;
  logic               r_rx_valid, r_frame_err;
  logic               w_rx_fall, w_rx_half, w_rx_full, w_rx_cnt_clr;

  assign w_rx_fall = r_rx_prev & ~r_rx_s2;
  assign w_rx_half = (r_rx_cnt == c_HALF_LAST);
  assign w_rx_full = (r_rx_cnt == c_BIT_LAST);
  assign w_rx_cnt_clr = (r_rx_state == RX_IDLE) ||
                        ((r_rx_state == RX_START) && w_rx_half) ||
                        ((r_rx_state == RX_DATA || r_rx_state == RX_STOP) && w_rx_full);

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      RX_IDLE:  if (w_rx_fall) w_rx_next = RX_START;
      RX_START: if (w_rx_half) w_rx_next = r_rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_rx_full && r_rx_bit == 3'd7) w_rx_next = RX_STOP;
      RX_STOP:  if (w_rx_full) w_rx_next = RX_IDLE;
      default:  w_rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) r_rx_state <= RX_IDLE;
    else      r_rx_state <= w_rx_next;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rx_s1     <= 1'b1;
      r_rx_s2     <= 1'b1;
      r_rx_prev   <= 1'b1;
      r_rx_cnt    <= '0;
      r_rx_bit    <= '0;
      r_rx_shift  <= '0;
      r_rx_byte   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_s1    <= rx;
      r_rx_s2    <= r_rx_s1;
      r_rx_prev  <= r_rx_s2;
      r_rx_valid <= 1'b0;
      r_rx_cnt   <= w_rx_cnt_clr ? '0 : r_rx_cnt + 1'b1;
      if (r_rx_state == RX_START && w_rx_half) r_rx_bit <= '0;
      if (r_rx_state == RX_DATA && w_rx_full) begin
        r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
        r_rx_bit   <= r_rx_bit + 1'b1;
      end
      if (r_rx_state == RX_STOP && w_rx_full) begin
        if (r_rx_s2) begin
          r_rx_byte  <= r_rx_shift;
          r_rx_valid <= 1'b1;
        end else begin
          r_frame_err <= 1'b1;
        end
      end
    end
  end

  // ------------------------------------------------------------ loader FSM
  typedef enum logic [1:0] {ST_HUNT, ST_LOAD, ST_DONE} ld_state_t;

  ld_state_t              r_ld_state, w_ld_next;
  logic [3:0]             r_match;
  logic [c_LANE_W-1:0]    r_lane;
  logic [8*WORD_BYTES-1:0] r_word, w_word, r_wdata;
  logic [ADDR_W-1:0]      r_addr;
  logic [c_TO_W-1:0]      r_timeout;
  logic                   r_we;
  logic                   w_key_hit, w_timeout, w_partial;

  assign w_key_hit = r_rx_valid && (r_rx_byte == key_byte(r_match));
  assign w_timeout = (r_timeout >= c_TIMEOUT);
  assign w_partial = (r_lane != '0);

  always_comb begin
    w_word = r_word;
    w_word[{r_lane, 3'b000} +: 8] = r_rx_byte;
  end

  // A pending partial word is flushed while still in LOAD; DONE follows once lanes are empty.
  always_comb begin
    w_ld_next = r_ld_state;
    if (!load_en) begin
      w_ld_next = ST_HUNT;
    end else begin
      case (r_ld_state)
        ST_HUNT: if (w_key_hit && r_match == c_KEY_LAST) w_ld_next = ST_LOAD;
        ST_LOAD: if (w_timeout && !r_rx_valid && !w_partial) w_ld_next = ST_DONE;
        ST_DONE: w_ld_next = ST_DONE;
        default: w_ld_next = ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) r_ld_state <= ST_HUNT;
    else      r_ld_state <= w_ld_next;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_match   <= '0;
      r_lane    <= '0;
      r_word    <= '0;
      r_wdata   <= '0;
      r_addr    <= '0;
      r_timeout <= '0;
      r_we      <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (r_we) r_addr <= r_addr + 1'b1;
      if (!load_en) begin
        r_match <= '0;
        r_lane  <= '0;
        r_word  <= '0;
      end else begin
        case (r_ld_state)
          ST_HUNT: begin
            if (r_rx_valid) begin
              if (w_key_hit)
                r_match <= (r_match == c_KEY_LAST) ? 4'd0 : r_match + 4'd1;
              else
                r_match <= (r_rx_byte == 8'h54) ? 4'd1 : 4'd0;
            end
            if (w_ld_next == ST_LOAD) begin
              r_addr    <= '0;
              r_lane    <= '0;
              r_word    <= '0;
              r_timeout <= '0;
            end
          end
          ST_LOAD: begin
            if (r_rx_valid) begin
              r_timeout <= '0;
              if (r_lane == c_LAST_LANE) begin
                r_we    <= 1'b1;
                r_wdata <= w_word;
                r_lane  <= '0;
                r_word  <= '0;
              end else begin
                r_word <= w_word;
                r_lane <= r_lane + 1'b1;
              end
            end else begin
              r_timeout <= r_timeout + 1'b1;
              if (w_timeout && w_partial) begin
                r_we    <= 1'b1;
                r_wdata <= r_word;
                r_lane  <= '0;
                r_word  <= '0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign loading    = (r_ld_state == ST_LOAD);
  assign done       = (r_ld_state == ST_DONE);
  assign frame_err  = r_frame_err;

  // ------------------------------------------------------------ echo
`ifdef UART_IMEM_LOADER_ECHO_EN
  logic               r_tx, r_tx_busy;
  logic [8:0]         r_tx_shift;
  logic [c_DIV_W-1:0] r_tx_cnt;
  logic [3:0]         r_tx_bits;
  logic               w_echo;

  assign w_echo = r_rx_valid && load_en && (r_ld_state == ST_LOAD);

  // Start bit goes out immediately; shift holds data then stop, sent LSB first.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tx       <= 1'b1;
      r_tx_busy  <= 1'b0;
      r_tx_shift <= '1;
      r_tx_cnt   <= '0;
      r_tx_bits  <= '0;
    end else if (!r_tx_busy) begin
      if (w_echo) begin
        r_tx       <= 1'b0;
        r_tx_busy  <= 1'b1;
        r_tx_shift <= {1'b1, r_rx_byte};
        r_tx_cnt   <= '0;
        r_tx_bits  <= '0;
      end
    end else if (r_tx_cnt == c_BIT_LAST) begin
      r_tx_cnt <= '0;
      if (r_tx_bits == 4'd9) begin
        r_tx_busy <= 1'b0;
        r_tx      <= 1'b1;
      end else begin
        r_tx       <= r_tx_shift[0];
        r_tx_shift <= {1'b1, r_tx_shift[8:1]};
        r_tx_bits  <= r_tx_bits + 4'd1;
      end
    end else begin
      r_tx_cnt <= r_tx_cnt + 1'b1;
    end
  end

  assign tx = r_tx;
`else
  assign tx = 1'b1;
`endif

endmodule
`default_nettype wire
